// File: rtl/instr_decode_stage.sv
// Decode stage: classifies R/I/S opcodes, extracts fields and immediate, counts accepted instructions.
// Latency: 1 cycle from accepted input to registered bundle with out_valid.
// Backpressure: single skid-less register; in_ready = (!out_valid || out_ready) && !flush.
module instr_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            r_type,
    output logic            i_type,
    output logic            store,
    output logic            illegal,
    output logic [2:0]      func3,
    output logic [6:0]      fun7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [15:0]     instr_count
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            r_type_q, r_type_d;
    logic            i_type_q, i_type_d;
    logic            store_q, store_d;
    logic            illegal_q, illegal_d;
    logic [2:0]      func3_q, func3_d;
    logic [6:0]      fun7_q, fun7_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [15:0]     instr_count_q, instr_count_d;

    logic            accept;
    logic [6:0]      opcode;
    logic            dec_r, dec_i, dec_s;
    logic [XLEN-1:0] dec_imm;

    // Handshake: flush blocks acceptance so a discarded instruction is never counted
    always_comb begin
        in_ready = (!out_valid_q || out_ready) && !flush;
        accept   = in_valid && in_ready;
    end

    // Combinational decode of the incoming instruction word
    always_comb begin
        opcode  = in_instr[6:0];
        dec_r   = (opcode == OP_R);
        dec_i   = (opcode == OP_I);
        dec_s   = (opcode == OP_S);
        dec_imm = '0;
        if (dec_i) begin
            dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        end else if (dec_s) begin
            dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
    end

    // Next-state: bundle loads on accept, otherwise holds; valid drops on flush or drain
    always_comb begin
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        r_type_d      = r_type_q;
        i_type_d      = i_type_q;
        store_d       = store_q;
        illegal_d     = illegal_q;
        func3_d       = func3_q;
        fun7_d        = fun7_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        imm_d         = imm_q;
        instr_count_d = instr_count_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_pc_d      = in_pc;
            r_type_d      = dec_r;
            i_type_d      = dec_i;
            store_d       = dec_s;
            illegal_d     = !(dec_r || dec_i || dec_s);
            func3_d       = in_instr[14:12];
            fun7_d        = in_instr[31:25];
            rd_d          = in_instr[11:7];
            rs1_d         = in_instr[19:15];
            rs2_d         = in_instr[24:20];
            imm_d         = dec_imm;
            instr_count_d = instr_count_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear of the whole bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            r_type_q      <= 1'b0;
            i_type_q      <= 1'b0;
            store_q       <= 1'b0;
            illegal_q     <= 1'b0;
            func3_q       <= '0;
            fun7_q        <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            instr_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            r_type_q      <= r_type_d;
            i_type_q      <= i_type_d;
            store_q       <= store_d;
            illegal_q     <= illegal_d;
            func3_q       <= func3_d;
            fun7_q        <= fun7_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            imm_q         <= imm_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Drive outputs straight from the registers
    always_comb begin
        out_valid   = out_valid_q;
        out_pc      = out_pc_q;
        r_type      = r_type_q;
        i_type      = i_type_q;
        store       = store_q;
        illegal     = illegal_q;
        func3       = func3_q;
        fun7        = fun7_q;
        rd          = rd_q;
        rs1         = rs1_q;
        rs2         = rs2_q;
        imm         = imm_q;
        instr_count = instr_count_q;
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode of add/addi/sw/illegal, stall, flush,
// drain, counter wrap and asynchronous reset. Expected values are hand-computed constants.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        r_type, i_type, store, illegal;
    logic [2:0]  func3;
    logic [6:0]  fun7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [15:0] instr_count;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] I_ADD  = 32'h00A30333;
    localparam logic [31:0] I_ADDI = 32'hFFF28293;
    localparam logic [31:0] I_SW   = 32'hFE552E23;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    instr_decode_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .r_type      (r_type),
        .i_type      (i_type),
        .store       (store),
        .illegal     (illegal),
        .func3       (func3),
        .fun7        (fun7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = vld;
        in_instr = instr;
        in_pc    = pc;
    endtask

    // Flags packed as {r_type,i_type,store,illegal}
    task automatic chk_cls(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, r_type, i_type, store, illegal}, {28'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {16'd0, instr_count}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk_cls("rst_class", 4'b0000);
        chk("rst_fields", {7'd0, fun7, func3, rd, rs1, rs2}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // add x6,x6,x10
        drive(1'b1, I_ADD, 32'h100);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk_cls("add_class", 4'b1000);
        chk("add_rd", {27'd0, rd}, 32'd6);
        chk("add_rs1", {27'd0, rs1}, 32'd6);
        chk("add_rs2", {27'd0, rs2}, 32'd10);
        chk("add_func3", {29'd0, func3}, 32'd0);
        chk("add_fun7", {25'd0, fun7}, 32'd0);
        chk("add_imm", imm, 32'd0);
        chk("add_pc", out_pc, 32'h100);
        chk("add_count", {16'd0, instr_count}, 32'd1);

        // addi x5,x5,-1 back-to-back
        drive(1'b1, I_ADDI, 32'h104);
        tick();
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk_cls("addi_class", 4'b0100);
        chk("addi_rd", {27'd0, rd}, 32'd5);
        chk("addi_rs1", {27'd0, rs1}, 32'd5);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_fun7", {25'd0, fun7}, 32'h7F);
        chk("addi_count", {16'd0, instr_count}, 32'd2);

        // sw x5,-4(x10)
        drive(1'b1, I_SW, 32'h108);
        tick();
        chk_cls("sw_class", 4'b0010);
        chk("sw_rs1", {27'd0, rs1}, 32'd10);
        chk("sw_rs2", {27'd0, rs2}, 32'd5);
        chk("sw_func3", {29'd0, func3}, 32'd2);
        chk("sw_imm", imm, 32'hFFFFFFFC);
        chk("sw_pc", out_pc, 32'h108);
        chk("sw_count", {16'd0, instr_count}, 32'd3);

        // Stall three cycles with a pending add
        out_ready = 1'b0;
        drive(1'b1, I_ADD, 32'h10C);
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk_cls("stall_class", 4'b0010);
            chk("stall_imm", imm, 32'hFFFFFFFC);
            chk("stall_pc", out_pc, 32'h108);
            chk("stall_count", {16'd0, instr_count}, 32'd3);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_cls("unstall_add_class", 4'b1000);
        chk("unstall_add_pc", out_pc, 32'h10C);
        chk("unstall_count", {16'd0, instr_count}, 32'd4);
        drive(1'b1, I_ADDI, 32'h110);
        tick();
        chk_cls("b2b_addi_class", 4'b0100);
        chk("b2b_count", {16'd0, instr_count}, 32'd5);

        // Illegal opcode
        drive(1'b1, I_BAD, 32'h114);
        tick();
        chk("bad_valid", {31'd0, out_valid}, 32'd1);
        chk_cls("bad_class", 4'b0001);
        chk("bad_imm", imm, 32'd0);
        chk("bad_count", {16'd0, instr_count}, 32'd6);

        // Flush with a valid incoming instruction
        flush = 1'b1;
        drive(1'b1, I_ADD, 32'h118);
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_count", {16'd0, instr_count}, 32'd6);
        chk("flush_pc_kept", out_pc, 32'h114);
        flush = 1'b0;
        drive(1'b0, I_ADD, 32'h118);
        tick();
        chk("post_flush_valid", {31'd0, out_valid}, 32'd0);

        // Single transfer then drain
        drive(1'b1, I_SW, 32'h11C);
        tick();
        chk("drain_load_count", {16'd0, instr_count}, 32'd7);
        drive(1'b0, I_ADD, 32'h120);
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_pc_kept", out_pc, 32'h11C);
        chk("drain_imm_kept", imm, 32'hFFFFFFFC);

        // Counter wrap: reset then 65535 back-to-back transfers
        rst_n = 1'b0;
        #1;
        chk("rst2_count", {16'd0, instr_count}, 32'd0);
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, I_ADD, 32'h200);
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        chk("wrap_pre_count", {16'd0, instr_count}, 32'h0000FFFF);
        tick();
        chk("wrap_count", {16'd0, instr_count}, 32'd0);
        chk("wrap_valid", {31'd0, out_valid}, 32'd1);

        // Reset asserted mid-stall clears immediately
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_count", {16'd0, instr_count}, 32'd0);
        chk("async_rst_pc", out_pc, 32'd0);
        chk_cls("async_rst_class", 4'b0000);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, I_SW, 32'h300);
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_count", {16'd0, instr_count}, 32'd1);
        chk("post_rst_pc", out_pc, 32'h300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/PC/immediate width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream (fetch) instruction valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 SHALL have port in_instr  input  XLEN  raw instruction word.
REQ-007 SHALL have port in_pc  input  XLEN  PC of in_instr.
REQ-008 SHALL have port flush  input  1  discard held and incoming instruction.
REQ-009 SHALL have port out_valid  output  1  decoded bundle valid to the control-signal decoder.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the bundle.
REQ-011 SHALL have port out_pc  output  XLEN  registered PC.
REQ-012 SHALL have ports r_type, i_type, store  output  1 each  one-hot instruction class.
REQ-013 SHALL have port illegal  output  1  opcode not R/I/S.
REQ-014 SHALL have ports func3 (3), fun7 (7), rd (5), rs1 (5), rs2 (5)  output  instruction fields.
REQ-015 SHALL have port imm  output  XLEN  sign-extended immediate.
REQ-016 SHALL have port instr_count  output  16  accepted-instruction counter.

Function
REQ-017 Opcode instr[6:0]: 0110011 -> r_type; 0010011 -> i_type; 0100011 -> store; any other -> illegal=1, r_type=i_type=store=0.
REQ-018 Exactly one of r_type, i_type, store, illegal SHALL be 1 whenever out_valid=1.
REQ-019 Fields: func3=instr[14:12], fun7=instr[31:25], rd=instr[11:7], rs1=instr[19:15], rs2=instr[24:20], extracted for every opcode.
REQ-020 imm: i_type -> sign-extend instr[31:20]; store -> sign-extend {instr[31:25],instr[11:7]}; r_type/illegal -> 0.
REQ-021 in_ready SHALL be combinational: (!out_valid || out_ready) && !flush.
REQ-022 Transfer in occurs when in_valid && in_ready; decoded bundle registered, out_valid=1 on the next edge (latency 1 cycle).
REQ-023 Full throughput: out_valid && out_ready && in_valid in one cycle SHALL replace the bundle with the new one, out_valid stays 1.
REQ-024 out_valid && out_ready && !in_valid SHALL clear out_valid on the next edge.
REQ-025 While out_valid && !out_ready all outputs SHALL hold stable.
REQ-026 flush=1 SHALL clear out_valid on the next edge regardless of out_ready/in_valid; the incoming instruction that cycle is not accepted and not counted.
REQ-027 instr_count SHALL increment by 1 per accepted transfer (REQ-022), including illegal opcodes; wraps 0xFFFF -> 0x0000.
REQ-028 Data outputs when out_valid=0 SHALL retain last values (don't-care to downstream).

Reset
REQ-029 rst_n=0 SHALL immediately force out_valid=0, instr_count=0, out_pc=0, imm=0, all fields and class flags 0, independent of clk.
REQ-030 Reset mid-transfer SHALL drop the held bundle; first valid after rst_n release is accepted on the first rising edge with in_ready=1.

Verification
REQ-031 in_instr=0x00A30333 (add), in_pc=0x100, out_ready=1 -> next cycle out_valid=1, r_type=1, rd=6, rs1=6, rs2=10, func3=0, fun7=0, imm=0, out_pc=0x100, instr_count=1.
REQ-032 in_instr=0xFFF28293 (addi x5,x5,-1) -> i_type=1, rd=5, rs1=5, imm=0xFFFFFFFF.
REQ-033 in_instr=0xFE552E23 (sw x5,-4(x10)) -> store=1, rs1=10, rs2=5, func3=2, imm=0xFFFFFFFC.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, instr_count unchanged; out_ready=1 -> back-to-back transfers one per cycle.
REQ-035 in_instr=0x0000007F -> illegal=1, class flags 0; then flush=1 with in_valid=1 -> out_valid=0 next cycle, instr_count unchanged.
REQ-036 Preload instr_count=0xFFFF via 65535 transfers, one more -> instr_count=0x0000; assert rst_n=0 mid-stall -> out_valid=0 immediately.
